xunit_sha_compress: RTL and testbench

XUNIT_SHA_COMPRESS -- requirements
Module: xunit_sha_compress

---
 rtl/xunit_sha_compress.sv | 219 +++++++++++++++++++++
 tb/tb_xunit_sha_compress.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xunit_sha_compress.sv
// SHA-2 compression core: one round per running cycle, SHA-256 or SHA-512
// family selected by WORD_W, optional feed-forward of the initial state.
module xunit_sha_compress #(
    parameter int DELAY_W = 32,
    parameter int WORD_W  = 32,
    parameter int ROUNDS  = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               running,
    input  logic               run,
    output logic               done,
    input  logic [WORD_W-1:0]  in0,
    input  logic [WORD_W-1:0]  in1,
    input  logic [WORD_W-1:0]  in2,
    input  logic [WORD_W-1:0]  in3,
    input  logic [WORD_W-1:0]  in4,
    input  logic [WORD_W-1:0]  in5,
    input  logic [WORD_W-1:0]  in6,
    input  logic [WORD_W-1:0]  in7,
    input  logic [WORD_W-1:0]  in8,
    input  logic [WORD_W-1:0]  in9,
    output logic [WORD_W-1:0]  out0,
    output logic [WORD_W-1:0]  out1,
    output logic [WORD_W-1:0]  out2,
    output logic [WORD_W-1:0]  out3,
    output logic [WORD_W-1:0]  out4,
    output logic [WORD_W-1:0]  out5,
    output logic [WORD_W-1:0]  out6,
    output logic [WORD_W-1:0]  out7,
    input  logic [DELAY_W-1:0] delay0,
    input  logic               feedforward0
);

    generate
        if (WORD_W != 32 && WORD_W != 64) begin : g_bad_word
            $error("xunit_sha_compress: WORD_W must be 32 or 64");
        end
        if (ROUNDS < 1 || ROUNDS > 255) begin : g_bad_rounds
            $error("xunit_sha_compress: ROUNDS must be in 1..255");
        end
    endgenerate

    // Index of the final round, compared against the round counter.
    localparam logic [7:0] LAST_RND = 8'(ROUNDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        DELAY,
        ROUND,
        FINAL,
        FIN
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [DELAY_W-1:0]  delay_q;
    logic [7:0]          cnt_q;
    logic                ff_q;
    logic [WORD_W-1:0]   st_q   [0:7];
    logic [WORD_W-1:0]   h_q    [0:7];
    logic [WORD_W-1:0]   init_w [0:7];
    logic [WORD_W-1:0]   src    [0:7];
    logic [WORD_W-1:0]   rnd    [0:7];
    logic [WORD_W-1:0]   t1;
    logic [WORD_W-1:0]   t2;
    logic                start;
    logic                dec_delay;
    logic                do_round;
    logic                first_round;
    logic                do_final;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
        rotr = (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] big_sigma0(input logic [WORD_W-1:0] x);
        if (WORD_W == 32) big_sigma0 = rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
        else              big_sigma0 = rotr(x, 28) ^ rotr(x, 34) ^ rotr(x, 39);
    endfunction

    function automatic logic [WORD_W-1:0] big_sigma1(input logic [WORD_W-1:0] x);
        if (WORD_W == 32) big_sigma1 = rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
        else              big_sigma1 = rotr(x, 14) ^ rotr(x, 18) ^ rotr(x, 41);
    endfunction

    function automatic logic [WORD_W-1:0] ch(input logic [WORD_W-1:0] e,
                                             input logic [WORD_W-1:0] f,
                                             input logic [WORD_W-1:0] g);
        ch = (e & f) ^ (~e & g);
    endfunction

    function automatic logic [WORD_W-1:0] maj(input logic [WORD_W-1:0] a,
                                              input logic [WORD_W-1:0] b,
                                              input logic [WORD_W-1:0] c);
        maj = (a & b) ^ (a & c) ^ (b & c);
    endfunction

    // Gather the initial-state ports into an array for round 0 and H capture.
    always_comb begin
        init_w[0] = in0;
        init_w[1] = in1;
        init_w[2] = in2;
        init_w[3] = in3;
        init_w[4] = in4;
        init_w[5] = in5;
        init_w[6] = in6;
        init_w[7] = in7;
    end

    // One SHA-2 round; round 0 (issued from DELAY) works on the input state.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            src[i] = (state_q == DELAY) ? init_w[i] : st_q[i];
        end
        t1 = src[7] + big_sigma1(src[4]) + ch(src[4], src[5], src[6]) + in9 + in8;
        t2 = big_sigma0(src[0]) + maj(src[0], src[1], src[2]);
        rnd[0] = t1 + t2;
        rnd[1] = src[0];
        rnd[2] = src[1];
        rnd[3] = src[2];
        rnd[4] = src[3] + t1;
        rnd[5] = src[4];
        rnd[6] = src[5];
        rnd[7] = src[6];
    end

    // Next-state and datapath strobes; run overrides everything else.
    always_comb begin
        state_d     = state_q;
        start       = 1'b0;
        dec_delay   = 1'b0;
        do_round    = 1'b0;
        first_round = 1'b0;
        do_final    = 1'b0;
        if (run) begin
            start   = 1'b1;
            state_d = DELAY;
        end else begin
            case (state_q)
                DELAY: begin
                    if (delay_q != '0) begin
                        dec_delay = 1'b1;
                    end else if (running) begin
                        do_round    = 1'b1;
                        first_round = 1'b1;
                        if (ROUNDS == 1) state_d = ff_q ? FINAL : FIN;
                        else             state_d = ROUND;
                    end
                end
                ROUND: begin
                    if (running) begin
                        do_round = 1'b1;
                        if (cnt_q == LAST_RND) state_d = ff_q ? FINAL : FIN;
                    end
                end
                FINAL: begin
                    if (running) begin
                        do_final = 1'b1;
                        state_d  = FIN;
                    end
                end
                default: ;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Block configuration: start delay, round counter and feed-forward flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            delay_q <= '0;
            cnt_q   <= '0;
            ff_q    <= 1'b0;
        end else if (start) begin
            delay_q <= delay0;
            cnt_q   <= '0;
            ff_q    <= feedforward0;
        end else begin
            if (dec_delay) delay_q <= delay_q - DELAY_W'(1);
            if (do_round)  cnt_q   <= cnt_q + 8'd1;
        end
    end

    // Working state a..h and saved initial state H0..H7.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                st_q[i] <= '0;
                h_q[i]  <= '0;
            end
        end else begin
            if (first_round) begin
                for (int i = 0; i < 8; i++) h_q[i] <= init_w[i];
            end
            if (do_round) begin
                for (int i = 0; i < 8; i++) st_q[i] <= rnd[i];
            end else if (do_final) begin
                for (int i = 0; i < 8; i++) st_q[i] <= st_q[i] + h_q[i];
            end
        end
    end

    assign done = (state_q == IDLE) || (state_q == FIN);
    assign out0 = st_q[0];
    assign out1 = st_q[1];
    assign out2 = st_q[2];
    assign out3 = st_q[3];
    assign out4 = st_q[4];
    assign out5 = st_q[5];
    assign out6 = st_q[6];
    assign out7 = st_q[7];

endmodule

// File: tb/tb_xunit_sha_compress.sv
// Self-checking bench for xunit_sha_compress: SHA-256 and SHA-512 instances
// checked round by round against a plain compression-loop reference model.
module tb_xunit_sha_compress;

    localparam logic [63:0] K512 [0:79] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    localparam logic [63:0] IV512 [0:7] = '{
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
    };

    localparam logic [31:0] ABC256 [0:7] = '{
        32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
        32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad
    };

    logic        clk = 1'b0;
    logic        rst;
    logic        running;
    logic        run32;
    logic        run64;
    logic        ff_cfg;
    logic [31:0] dly;
    logic [63:0] in_v [0:7];
    logic [63:0] w_in;
    logic [63:0] k_in;
    logic [31:0] o32  [0:7];
    logic [63:0] o64  [0:7];
    logic        done32;
    logic        done64;

    int n_cmp;
    int n_err;

    logic [63:0] mdl_iv  [0:7];
    logic [63:0] mdl_w   [0:79];
    logic [63:0] mdl_k   [0:79];
    logic [63:0] mdl_tr  [0:80][0:7];
    logic [63:0] mdl_dig [0:7];

    always #5 clk = ~clk;

    xunit_sha_compress #(.DELAY_W(32), .WORD_W(32), .ROUNDS(64)) dut32 (
        .clk(clk), .rst(rst), .running(running), .run(run32), .done(done32),
        .in0(in_v[0][31:0]), .in1(in_v[1][31:0]), .in2(in_v[2][31:0]), .in3(in_v[3][31:0]),
        .in4(in_v[4][31:0]), .in5(in_v[5][31:0]), .in6(in_v[6][31:0]), .in7(in_v[7][31:0]),
        .in8(w_in[31:0]), .in9(k_in[31:0]),
        .out0(o32[0]), .out1(o32[1]), .out2(o32[2]), .out3(o32[3]),
        .out4(o32[4]), .out5(o32[5]), .out6(o32[6]), .out7(o32[7]),
        .delay0(dly), .feedforward0(ff_cfg)
    );

    xunit_sha_compress #(.DELAY_W(32), .WORD_W(64), .ROUNDS(80)) dut64 (
        .clk(clk), .rst(rst), .running(running), .run(run64), .done(done64),
        .in0(in_v[0]), .in1(in_v[1]), .in2(in_v[2]), .in3(in_v[3]),
        .in4(in_v[4]), .in5(in_v[5]), .in6(in_v[6]), .in7(in_v[7]),
        .in8(w_in), .in9(k_in),
        .out0(o64[0]), .out1(o64[1]), .out2(o64[2]), .out3(o64[3]),
        .out4(o64[4]), .out5(o64[5]), .out6(o64[6]), .out7(o64[7]),
        .delay0(dly), .feedforward0(ff_cfg)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [63:0] get_out(input bit wide, input int i);
        return wide ? o64[i] : {32'b0, o32[i]};
    endfunction

    function automatic logic [63:0] get_done(input bit wide);
        return wide ? {63'b0, done64} : {63'b0, done32};
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [63:0] msk(input bit wide);
        return wide ? 64'hffff_ffff_ffff_ffff : 64'h0000_0000_ffff_ffff;
    endfunction

    function automatic logic [63:0] rr(input logic [63:0] x, input int n, input bit wide);
        int w;
        w = wide ? 64 : 32;
        return ((x >> n) | (x << (w - n))) & msk(wide);
    endfunction

    function automatic logic [63:0] bs0(input logic [63:0] x, input bit wide);
        return wide ? (rr(x, 28, 1) ^ rr(x, 34, 1) ^ rr(x, 39, 1))
                    : (rr(x, 2, 0) ^ rr(x, 13, 0) ^ rr(x, 22, 0));
    endfunction

    function automatic logic [63:0] bs1(input logic [63:0] x, input bit wide);
        return wide ? (rr(x, 14, 1) ^ rr(x, 18, 1) ^ rr(x, 41, 1))
                    : (rr(x, 6, 0) ^ rr(x, 11, 0) ^ rr(x, 25, 0));
    endfunction

    function automatic logic [63:0] ss0(input logic [63:0] x, input bit wide);
        return wide ? (rr(x, 1, 1) ^ rr(x, 8, 1) ^ (x >> 7))
                    : (rr(x, 7, 0) ^ rr(x, 18, 0) ^ (x >> 3));
    endfunction

    function automatic logic [63:0] ss1(input logic [63:0] x, input bit wide);
        return wide ? (rr(x, 19, 1) ^ rr(x, 61, 1) ^ (x >> 6))
                    : (rr(x, 17, 0) ^ rr(x, 19, 0) ^ (x >> 10));
    endfunction

    // Reference: textbook compression loop, recording the state after each round.
    task automatic sha_model(input bit wide, input int nr, input bit ff);
        logic [63:0] m;
        logic [63:0] s [0:7];
        logic [63:0] t1;
        logic [63:0] t2;
        m = msk(wide);
        for (int i = 0; i < 8; i++) begin
            s[i] = mdl_iv[i] & m;
            mdl_tr[0][i] = s[i];
        end
        for (int r = 0; r < nr; r++) begin
            t1 = (s[7] + bs1(s[4], wide) + ((s[4] & s[5]) ^ (~s[4] & s[6] & m))
                  + mdl_k[r] + mdl_w[r]) & m;
            t2 = (bs0(s[0], wide) + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]))) & m;
            for (int i = 7; i > 0; i--) s[i] = s[i-1];
            s[4] = (s[4] + t1) & m;
            s[0] = (t1 + t2) & m;
            for (int i = 0; i < 8; i++) mdl_tr[r+1][i] = s[i];
        end
        for (int i = 0; i < 8; i++) mdl_dig[i] = ff ? ((s[i] + mdl_iv[i]) & m) : s[i];
    endtask

    // Standard IV, constants and message schedule of the padded "abc" block.
    task automatic load_abc(input bit wide);
        logic [63:0] kk;
        logic [63:0] m;
        m = msk(wide);
        for (int i = 0; i < 8; i++) begin
            kk = IV512[i];
            mdl_iv[i] = wide ? kk : {32'b0, kk[63:32]};
        end
        for (int t = 0; t < 80; t++) begin
            kk = K512[t];
            mdl_k[t] = wide ? kk : {32'b0, kk[63:32]};
            if (t == 0)       mdl_w[t] = wide ? 64'h6162638000000000 : 64'h61626380;
            else if (t == 15) mdl_w[t] = 64'h18;
            else if (t < 16)  mdl_w[t] = 64'h0;
            else mdl_w[t] = (ss1(mdl_w[t-2], wide) + mdl_w[t-7]
                             + ss0(mdl_w[t-15], wide) + mdl_w[t-16]) & m;
        end
    endtask

    task automatic load_rand();
        for (int i = 0; i < 8; i++) mdl_iv[i] = rnd64();
        for (int t = 0; t < 80; t++) begin
            mdl_w[t] = rnd64();
            mdl_k[t] = rnd64();
        end
    endtask

    // Drive one block starting at a negedge and check every edge against the model.
    task automatic run_blk(input bit wide, input int d, input bit ff, input int nr,
                           input int stall_pct, input int stall_at, input int abort_at);
        logic [63:0] snap [0:7];
        int r;
        int guard;
        int stall_left;
        bit stalled_once;
        sha_model(wide, nr, ff);
        stalled_once = 0;
        stall_left = 0;
        for (int i = 0; i < 8; i++) begin
            in_v[i] = mdl_iv[i];
            snap[i] = get_out(wide, i);
        end
        dly = 32'(d);
        ff_cfg = ff;
        running = 1'($urandom_range(0, 1));
        if (wide) run64 = 1'b1; else run32 = 1'b1;
        @(posedge clk); @(negedge clk);
        run32 = 1'b0;
        run64 = 1'b0;
        chk("start_done", get_done(wide), 64'd0);
        for (int i = 0; i < d; i++) begin
            running = 1'($urandom_range(0, 1));
            w_in = rnd64();
            k_in = rnd64();
            @(posedge clk); @(negedge clk);
            for (int j = 0; j < 8; j++) chk("delay_hold", get_out(wide, j), snap[j]);
            chk("delay_done", get_done(wide), 64'd0);
        end
        r = 0;
        guard = 0;
        while (r < nr && guard < 2000) begin
            if (r == stall_at && !stalled_once) begin
                stall_left = 5;
                stalled_once = 1;
            end
            if (stall_left > 0) begin
                running = 1'b0;
                stall_left--;
            end else begin
                running = ($urandom_range(0, 99) >= stall_pct);
            end
            if (running) begin
                w_in = mdl_w[r];
                k_in = mdl_k[r];
            end else begin
                w_in = rnd64();
                k_in = rnd64();
            end
            @(posedge clk); @(negedge clk);
            guard++;
            if (running) r++;
            for (int j = 0; j < 8; j++)
                chk(running ? "round_state" : "stall_hold", get_out(wide, j), mdl_tr[r][j]);
            chk("round_done", get_done(wide), {63'b0, (r == nr && !ff)});
            if (r == abort_at) begin
                #1 rst = 1'b1;
                #1;
                for (int j = 0; j < 8; j++) chk("abort_out", get_out(wide, j), 64'd0);
                chk("abort_done", get_done(wide), 64'd1);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
        end
        chk("round_count", 64'(r), 64'(nr));
        if (ff) begin
            guard = 0;
            do begin
                running = (guard >= 20) || ($urandom_range(0, 99) >= stall_pct);
                w_in = rnd64();
                k_in = rnd64();
                @(posedge clk); @(negedge clk);
                guard++;
                if (!running) begin
                    for (int j = 0; j < 8; j++) chk("final_hold", get_out(wide, j), mdl_tr[nr][j]);
                    chk("final_done", get_done(wide), 64'd0);
                end
            end while (!running);
        end
        for (int j = 0; j < 8; j++) chk("digest", get_out(wide, j), mdl_dig[j]);
        chk("end_done", get_done(wide), 64'd1);
        repeat (2) begin
            running = 1'($urandom_range(0, 1));
            w_in = rnd64();
            k_in = rnd64();
            @(posedge clk); @(negedge clk);
            for (int j = 0; j < 8; j++) chk("fin_hold", get_out(wide, j), mdl_dig[j]);
            chk("fin_done", get_done(wide), 64'd1);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        running = 1'b0;
        run32 = 1'b0;
        run64 = 1'b0;
        ff_cfg = 1'b0;
        dly = '0;
        w_in = '0;
        k_in = '0;
        for (int i = 0; i < 8; i++) in_v[i] = '0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            chk("reset_out32", get_out(0, i), 64'd0);
            chk("reset_out64", get_out(1, i), 64'd0);
        end
        chk("reset_done32", get_done(0), 64'd1);
        chk("reset_done64", get_done(1), 64'd1);
        rst = 1'b0;
        @(negedge clk);

        // SHA-256 "abc", no delay, no stalls.
        load_abc(0);
        run_blk(0, 0, 1, 64, 0, -1, -1);
        for (int i = 0; i < 8; i++) chk("abc256", get_out(0, i), {32'b0, ABC256[i]});

        // SHA-512 "abc".
        load_abc(1);
        run_blk(1, 0, 1, 80, 0, -1, -1);
        chk("abc512_out0", get_out(1, 0), 64'hddaf35a193617aba);
        chk("abc512_out7", {32'b0, o64[7][31:0]}, 64'h00000000a54ca49f);

        // Start delay of 3.
        load_abc(0);
        run_blk(0, 3, 1, 64, 0, -1, -1);
        for (int i = 0; i < 8; i++) chk("abc256_delay", get_out(0, i), {32'b0, ABC256[i]});

        // Five-cycle stall in the middle of the rounds.
        load_abc(0);
        run_blk(0, 1, 1, 64, 0, 30, -1);
        for (int i = 0; i < 8; i++) chk("abc256_stall", get_out(0, i), {32'b0, ABC256[i]});

        // All-zero block without feed-forward.
        for (int i = 0; i < 8; i++) mdl_iv[i] = '0;
        for (int t = 0; t < 80; t++) begin
            mdl_w[t] = '0;
            mdl_k[t] = '0;
        end
        run_blk(0, 0, 0, 64, 0, -1, -1);
        for (int i = 0; i < 8; i++) chk("zero_out", get_out(0, i), 64'd0);

        // Reset at round 20, then a clean "abc" block.
        load_abc(0);
        run_blk(0, 0, 1, 64, 0, -1, 20);
        load_abc(0);
        run_blk(0, 0, 1, 64, 0, -1, -1);
        for (int i = 0; i < 8; i++) chk("abc256_after_rst", get_out(0, i), {32'b0, ABC256[i]});

        // Random blocks with random delay, feed-forward and stalls.
        for (int b = 0; b < 4; b++) begin
            load_rand();
            run_blk(0, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 64, 25, -1, -1);
        end
        for (int b = 0; b < 2; b++) begin
            load_rand();
            run_blk(1, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 80, 25, -1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
